alu_sequencer: RTL

- Multi-cycle control FSM that owns the 16-bit ALU.
- Accepts one instruction word over a valid/ready handshake and decodes it into the 8-bit ALU operation code, operand selects and immediate.
- Sequences decode, execute and writeback, latches the processor status flags, and hands memory/branch instructions to an external unit via a request/done handshake.
- Sits between the instruction fetch path and the ALU/register-file datapath.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/alu_decode.sv | 93 +++++++++
 rtl/alu_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: major opcodes, opcode extensions,
// sequencer state encoding and PSR bit positions.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_RSV7  = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_RSVA  = 4'b1010;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] X_AND  = 4'b0001;
  localparam logic [3:0] X_OR   = 4'b0010;
  localparam logic [3:0] X_XOR  = 4'b0011;
  localparam logic [3:0] X_ADD  = 4'b0101;
  localparam logic [3:0] X_ADDU = 4'b0110;
  localparam logic [3:0] X_ADDC = 4'b0111;
  localparam logic [3:0] X_SUB  = 4'b1001;
  localparam logic [3:0] X_SUBC = 4'b1010;
  localparam logic [3:0] X_CMP  = 4'b1011;
  localparam logic [3:0] X_MOV  = 4'b1101;

  localparam logic [3:0] X_LSHI0  = 4'b0000;
  localparam logic [3:0] X_LSHI1  = 4'b0001;
  localparam logic [3:0] X_ASHUI0 = 4'b0010;
  localparam logic [3:0] X_ASHUI1 = 4'b0011;
  localparam logic [3:0] X_LSH    = 4'b0100;
  localparam logic [3:0] X_ASHU   = 4'b0110;

  localparam logic [3:0] X_LOAD  = 4'b0000;
  localparam logic [3:0] X_STOR  = 4'b0100;
  localparam logic [3:0] X_JAL   = 4'b1000;
  localparam logic [3:0] X_JCOND = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_EXT_WAIT
  } state_t;

  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode: op + low byte -> ALU controls.
// Ports: op, low in; alu_op, use_imm, imm, writes_reg, sets_flags,
// is_ext, illegal out.
module alu_decode
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [7:0]       low,
  output logic [7:0]       alu_op,
  output logic             use_imm,
  output logic [WIDTH-1:0] imm,
  output logic             writes_reg,
  output logic             sets_flags,
  output logic             is_ext,
  output logic             illegal
);

  logic [3:0]       ext;
  logic [WIDTH-1:0] sext;
  logic [WIDTH-1:0] zext;

  assign ext  = low[7:4];
  assign sext = {{(WIDTH-8){low[7]}}, low};
  assign zext = {{(WIDTH-8){1'b0}}, low};

  always_comb begin
    alu_op     = {op, 4'b0000};
    use_imm    = 1'b1;
    imm        = zext;
    writes_reg = 1'b1;
    sets_flags = 1'b0;
    is_ext     = 1'b0;
    illegal    = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        alu_op  = {op, ext};
        use_imm = 1'b0;
        imm     = '0;
        case (ext)
          X_ADD, X_ADDU, X_ADDC,
          X_SUB, X_SUBC:
            sets_flags = 1'b1;
          X_CMP: begin
            sets_flags = 1'b1;
            writes_reg = 1'b0;
          end
          X_AND, X_OR, X_XOR, X_MOV: ;
          default: illegal = 1'b1;
        endcase
      end
      OP_SHIFT: begin
        alu_op  = {op, ext};
        use_imm = 1'b0;
        imm     = '0;
        case (ext)
          X_LSHI0, X_LSHI1,
          X_ASHUI0, X_ASHUI1: begin
            // immediate shift forms shift by one
            use_imm = 1'b1;
            imm     = WIDTH'(1);
          end
          X_LSH, X_ASHU: ;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_SUBI: begin
        imm        = sext;
        sets_flags = 1'b1;
      end
      OP_CMPI: begin
        imm        = sext;
        sets_flags = 1'b1;
        writes_reg = 1'b0;
      end
      OP_MOVI: imm = sext;
      OP_ADDUI: sets_flags = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ;
      OP_MEM, OP_BCOND: begin
        is_ext     = 1'b1;
        writes_reg = 1'b0;
      end
      OP_RSV7, OP_RSVA: illegal = 1'b1;
      default: ;
    endcase
    if (illegal) begin
      writes_reg = 1'b0;
      sets_flags = 1'b0;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control FSM: accepts an instruction, decodes it,
// sequences execute/writeback or hands off to the mem/branch unit.
// Ports: instr/instrValid/instrReady fetch handshake; aluOp, aluEnable,
// useImm, imm, srcAddr, destAddr, regWrite datapath controls; ALU flags
// in, psr out; extReq/extDone external handshake; pcAdvance, illegalOp.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        instr,
  input  logic               instrValid,
  output logic               instrReady,
  output logic [7:0]         aluOp,
  output logic               aluEnable,
  output logic               useImm,
  output logic [WIDTH-1:0]   imm,
  output logic [REGBITS-1:0] srcAddr,
  output logic [REGBITS-1:0] destAddr,
  output logic               regWrite,
  input  logic               aluCarry,
  input  logic               aluLow,
  input  logic               aluOverflow,
  input  logic               aluZero,
  input  logic               aluNegative,
  output logic [4:0]         psr,
  output logic               extReq,
  input  logic               extDone,
  output logic               pcAdvance,
  output logic               illegalOp
);

  state_t state, state_n;

  logic [15:0]      ir;
  logic [7:0]       d_op;
  logic             d_ui;
  logic [WIDTH-1:0] d_imm;
  logic             d_wr;
  logic             d_sf;
  logic             d_ext;
  logic             d_ill;
  logic             wr_q;
  logic             sf_q;

  alu_decode #(
    .WIDTH(WIDTH)
  ) u_dec (
    .op        (ir[15:12]),
    .low       (ir[7:0]),
    .alu_op    (d_op),
    .use_imm   (d_ui),
    .imm       (d_imm),
    .writes_reg(d_wr),
    .sets_flags(d_sf),
    .is_ext    (d_ext),
    .illegal   (d_ill)
  );

  assign srcAddr  = REGBITS'(ir[3:0]);
  assign destAddr = REGBITS'(ir[11:8]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    instrReady = 1'b0;
    aluEnable  = 1'b0;
    regWrite   = 1'b0;
    extReq     = 1'b0;
    pcAdvance  = 1'b0;
    illegalOp  = 1'b0;
    unique case (state)
      S_IDLE: begin
        instrReady = 1'b1;
        if (instrValid) state_n = S_DECODE;
      end
      S_DECODE: begin
        illegalOp = d_ill;
        if (d_ext)      state_n = S_EXT_WAIT;
        else if (d_ill) state_n = S_WRITEBACK;
        else            state_n = S_EXECUTE;
      end
      S_EXECUTE: begin
        aluEnable = 1'b1;
        state_n   = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        regWrite  = wr_q;
        pcAdvance = 1'b1;
        state_n   = S_IDLE;
      end
      S_EXT_WAIT: begin
        extReq = 1'b1;
        if (extDone) begin
          pcAdvance = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir     <= '0;
      aluOp  <= '0;
      useImm <= 1'b0;
      imm    <= '0;
      wr_q   <= 1'b0;
      sf_q   <= 1'b0;
      psr    <= '0;
    end else begin
      if (state == S_IDLE && instrValid)
        ir <= instr;
      // decode results held stable through EXECUTE/WRITEBACK
      if (state == S_DECODE) begin
        aluOp  <= d_op;
        useImm <= d_ui;
        imm    <= d_imm;
        wr_q   <= d_wr;
        sf_q   <= d_sf;
      end
      if (state == S_EXECUTE && sf_q) begin
        psr[PSR_C] <= aluCarry;
        psr[PSR_L] <= aluLow;
        psr[PSR_F] <= aluOverflow;
        psr[PSR_Z] <= aluZero;
        psr[PSR_N] <= aluNegative;
      end
    end
  end

endmodule
